// File: rtl/writeback_stage_pkg.sv
// Shared Y86-64 encodings for the write-back stage: register IDs, stat codes, icodes,
// status FSM states and the W stage-register layout.
package writeback_stage_pkg;

  localparam logic [3:0] RAX   = 4'h0;
  localparam logic [3:0] RCX   = 4'h1;
  localparam logic [3:0] RDX   = 4'h2;
  localparam logic [3:0] RBX   = 4'h3;
  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RBP   = 4'h5;
  localparam logic [3:0] RSI   = 4'h6;
  localparam logic [3:0] RDI   = 4'h7;
  localparam logic [3:0] R8    = 4'h8;
  localparam logic [3:0] R9    = 4'h9;
  localparam logic [3:0] R10   = 4'hA;
  localparam logic [3:0] R11   = 4'hB;
  localparam logic [3:0] R12   = 4'hC;
  localparam logic [3:0] R13   = 4'hD;
  localparam logic [3:0] R14   = 4'hE;
  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [2:0] SBUB = 3'd0;
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StHalt  = 2'd1,
    StFault = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [63:0] val_e;
    logic [63:0] val_m;
  } w_reg_t;

  localparam w_reg_t WBubble = '{
    stat:  SBUB,
    icode: INOP,
    dst_e: RNONE,
    dst_m: RNONE,
    val_e: 64'd0,
    val_m: 64'd0
  };

  function automatic logic is_fault(input logic [2:0] stat);
    return (stat == SADR) || (stat == SINS);
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Memory-to-write-back bus plus W-stage outputs. retired_o exists only when
// WB_RETIRE_CNT_EN is defined.
interface writeback_stage_if
`ifdef WB_RETIRE_CNT_EN
#(
  parameter int unsigned CNT_W = 32
)
`endif
;

  logic [2:0]  M_stat_i;
  logic [3:0]  M_icode_i;
  logic [3:0]  M_dstE_i;
  logic [3:0]  M_dstM_i;
  logic [63:0] M_valE_i;
  logic [63:0] m_valM_i;
  logic        W_stall_i;
  logic        W_bubble_i;

  logic [2:0]  W_stat_o;
  logic [3:0]  W_icode_o;
  logic [3:0]  W_dstE_o;
  logic [3:0]  W_dstM_o;
  logic [63:0] W_valE_o;
  logic [63:0] W_valM_o;
  logic [2:0]  stat_o;
  logic        halted_o;
`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_o;
`endif

  modport master (
`ifdef WB_RETIRE_CNT_EN
    input  retired_o,
`endif
    output M_stat_i, M_icode_i, M_dstE_i, M_dstM_i, M_valE_i, m_valM_i,
    output W_stall_i, W_bubble_i,
    input  W_stat_o, W_icode_o, W_dstE_o, W_dstM_o, W_valE_o, W_valM_o,
    input  stat_o, halted_o
  );

  modport slave (
`ifdef WB_RETIRE_CNT_EN
    output retired_o,
`endif
    input  M_stat_i, M_icode_i, M_dstE_i, M_dstM_i, M_valE_i, m_valM_i,
    input  W_stall_i, W_bubble_i,
    output W_stat_o, W_icode_o, W_dstE_o, W_dstM_o, W_valE_o, W_valM_o,
    output stat_o, halted_o
  );

endinterface

// File: rtl/wb_pipereg.sv
// Generic pipeline register: stall holds, bubble loads bubble_val_i, otherwise loads d_i.
module wb_pipereg #(
  parameter int unsigned       Width    = 1,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             bubble_i,
  input  logic [Width-1:0] bubble_val_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (!stall_i) begin
      q_d = bubble_i ? bubble_val_i : d_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= ResetVal;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/writeback_stage.sv
// Y86-64 write-back stage: W register, register-file write gating, run/halt/fault status
// FSM and, with WB_RETIRE_CNT_EN defined, a retired-instruction counter.
module writeback_stage
  import writeback_stage_pkg::*;
`ifdef WB_RETIRE_CNT_EN
#(
  parameter int unsigned CNT_W = 32
)
`endif
(
  input  logic             clk,
  input  logic             rst,
  writeback_stage_if.slave wb
);

  w_reg_t    m_in, w_q;
  logic      load_bubble;
  logic      advance;
  wb_state_e state_d, state_q;
  logic [2:0] stat_d, stat_q;
  logic       halted_d, halted_q;
  logic       dst_e_ok;

  always_comb begin
    m_in       = WBubble;
    m_in.stat  = wb.M_stat_i;
    m_in.icode = wb.M_icode_i;
    m_in.dst_e = wb.M_dstE_i;
    m_in.dst_m = wb.M_dstM_i;
    m_in.val_e = wb.M_valE_i;
    m_in.val_m = wb.m_valM_i;
  end

  // Once stopped, nothing further may enter W.
  assign load_bubble = wb.W_bubble_i || (state_q != StRun);
  assign advance     = !wb.W_stall_i;

  wb_pipereg #(
    .Width    ($bits(w_reg_t)),
    .ResetVal (WBubble)
  ) u_w_reg (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (wb.W_stall_i),
    .bubble_i     (load_bubble),
    .bubble_val_i (WBubble),
    .d_i          (m_in),
    .q_o          (w_q)
  );

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    if (advance && (state_q == StRun)) begin
      if (w_q.stat == SHLT) begin
        state_d = StHalt;
        stat_d  = SHLT;
      end else if (is_fault(w_q.stat)) begin
        state_d = StFault;
        stat_d  = w_q.stat;
      end
    end
    halted_d = (state_d != StRun);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StRun;
      stat_q   <= SAOK;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      stat_q   <= stat_d;
      halted_q <= halted_d;
    end
  end

  // popq %rsp: both ports target the same register, the loaded value (M port) wins.
  assign dst_e_ok = (w_q.stat == SAOK) &&
                    !((w_q.dst_e == w_q.dst_m) && (w_q.dst_e != RNONE));

  assign wb.W_stat_o  = w_q.stat;
  assign wb.W_icode_o = w_q.icode;
  assign wb.W_dstE_o  = dst_e_ok ? w_q.dst_e : RNONE;
  assign wb.W_dstM_o  = (w_q.stat == SAOK) ? w_q.dst_m : RNONE;
  assign wb.W_valE_o  = w_q.val_e;
  assign wb.W_valM_o  = w_q.val_m;
  assign wb.stat_o    = stat_q;
  assign wb.halted_o  = halted_q;

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_d, retired_q;

  always_comb begin
    retired_d = retired_q;
    if (advance && (state_q == StRun) && (w_q.stat == SAOK)) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign wb.retired_o = retired_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage; retired_o is checked when WB_RETIRE_CNT_EN is defined.
module tb_writeback_stage;

  logic clk;
  logic rst;

`ifdef WB_RETIRE_CNT_EN
  writeback_stage_if #(.CNT_W(32)) wb ();
  writeback_stage #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .wb(wb));
`else
  writeback_stage_if wb ();
  writeback_stage dut (.clk(clk), .rst(rst), .wb(wb));
`endif

  typedef struct {
    string       tag;
    logic [2:0]  wstat;
    logic [3:0]  wicode;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    logic [63:0] vale;
    logic [63:0] valm;
    logic [2:0]  stat;
    logic        halted;
    logic [31:0] retired;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t mk(input string tag, input logic [2:0] wstat,
                              input logic [3:0] wicode, input logic [3:0] dste,
                              input logic [3:0] dstm, input logic [63:0] vale,
                              input logic [63:0] valm, input logic [2:0] stat,
                              input logic halted, input logic [31:0] retired);
    exp_t e;
    e.tag = tag; e.wstat = wstat; e.wicode = wicode; e.dste = dste; e.dstm = dstm;
    e.vale = vale; e.valm = valm; e.stat = stat; e.halted = halted; e.retired = retired;
    return e;
  endfunction

  task automatic chk(input string tag, input string field, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s got=%0h want=%0h", tag, field, act, req);
    end
  endtask

  // Monitor: every cycle after an issued vector, pop and compare the W-side state.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk(e.tag, "W_stat",   64'(wb.W_stat_o),  64'(e.wstat));
        chk(e.tag, "W_icode",  64'(wb.W_icode_o), 64'(e.wicode));
        chk(e.tag, "W_dstE",   64'(wb.W_dstE_o),  64'(e.dste));
        chk(e.tag, "W_dstM",   64'(wb.W_dstM_o),  64'(e.dstm));
        chk(e.tag, "W_valE",   wb.W_valE_o,       e.vale);
        chk(e.tag, "W_valM",   wb.W_valM_o,       e.valm);
        chk(e.tag, "stat",     64'(wb.stat_o),    64'(e.stat));
        chk(e.tag, "halted",   64'(wb.halted_o),  64'(e.halted));
`ifdef WB_RETIRE_CNT_EN
        chk(e.tag, "retired",  64'(wb.retired_o), 64'(e.retired));
`endif
      end
    end
  end

  // Drive one vector just after a falling edge, then queue what must show after the next rise.
  task automatic drive(input logic r, input logic [2:0] st, input logic [3:0] ic,
                       input logic [3:0] de, input logic [3:0] dm, input logic [63:0] ve,
                       input logic [63:0] vm, input logic sl, input logic bb, input exp_t e);
    @(negedge clk);
    #1;
    rst           = r;
    wb.M_stat_i   = st;
    wb.M_icode_i  = ic;
    wb.M_dstE_i   = de;
    wb.M_dstM_i   = dm;
    wb.M_valE_i   = ve;
    wb.m_valM_i   = vm;
    wb.W_stall_i  = sl;
    wb.W_bubble_i = bb;
    @(posedge clk);
    sb.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 'x, 'x, 'x, 'x, 'x, 'x, 'x, 'x,
          mk("reset", 0, 1, 4'hF, 4'hF, 0, 0, 1, 0, 0));
    drive(0, 1, 4'h3, 4'h0, 4'hF, 64'h1234, 0, 0, 0,
          mk("irmovq", 1, 4'h3, 4'h0, 4'hF, 64'h1234, 0, 1, 0, 0));
    drive(0, 1, 4'hB, 4'h4, 4'h4, 64'h8, 64'hAA, 0, 0,
          mk("popq_conflict", 1, 4'hB, 4'hF, 4'h4, 64'h8, 64'hAA, 1, 0, 1));
    drive(0, 1, 4'h6, 4'h2, 4'hF, 64'h55, 0, 0, 0,
          mk("opq", 1, 4'h6, 4'h2, 4'hF, 64'h55, 0, 1, 0, 2));
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 4'h2, 4'(7 - i), 4'h3, 64'(99 + i), 64'(77 + i), 1, 1,
            mk("stall_bubble", 1, 4'h6, 4'h2, 4'hF, 64'h55, 0, 1, 0, 2));
    end
    drive(0, 1, 4'h3, 4'h1, 4'hF, 64'h5, 0, 0, 1,
          mk("bubble", 0, 1, 4'hF, 4'hF, 0, 0, 1, 0, 3));
    drive(0, 1, 4'h3, 4'h5, 4'hF, 64'h7, 0, 0, 0,
          mk("after_bubble", 1, 4'h3, 4'h5, 4'hF, 64'h7, 0, 1, 0, 3));
    drive(0, 2, 4'h0, 4'hF, 4'hF, 0, 0, 0, 0,
          mk("halt_enters", 2, 4'h0, 4'hF, 4'hF, 0, 0, 1, 0, 4));
    drive(0, 1, 4'h3, 4'h0, 4'hF, 64'h1, 0, 1, 0,
          mk("halt_stalled", 2, 4'h0, 4'hF, 4'hF, 0, 0, 1, 0, 4));
    drive(0, 1, 4'h3, 4'h0, 4'hF, 64'h1, 0, 0, 1,
          mk("halted", 0, 1, 4'hF, 4'hF, 0, 0, 2, 1, 4));
    drive(0, 1, 4'h3, 4'h0, 4'hF, 64'h1, 0, 0, 0,
          mk("halt_sticky", 0, 1, 4'hF, 4'hF, 0, 0, 2, 1, 4));
    drive(1, 1, 4'h3, 4'h0, 4'hF, 64'h1, 0, 0, 0,
          mk("rst_mid_halt", 0, 1, 4'hF, 4'hF, 0, 0, 1, 0, 0));
    drive(0, 3, 4'h5, 4'hF, 4'h3, 64'h10, 64'h20, 0, 0,
          mk("sadr_enters", 3, 4'h5, 4'hF, 4'hF, 64'h10, 64'h20, 1, 0, 0));
    drive(0, 1, 4'h3, 4'h2, 4'hF, 64'h9, 0, 0, 1,
          mk("fault", 0, 1, 4'hF, 4'hF, 0, 0, 3, 1, 0));
    drive(0, 4, 4'h3, 4'h2, 4'hF, 64'h9, 0, 0, 0,
          mk("fault_sticky", 0, 1, 4'hF, 4'hF, 0, 0, 3, 1, 0));
    drive(1, 1, 4'h3, 4'h2, 4'hF, 64'h9, 0, 1, 0,
          mk("rst_mid_fault", 0, 1, 4'hF, 4'hF, 0, 0, 1, 0, 0));
    drive(0, 4, 4'hF, 4'hF, 4'hF, 0, 0, 0, 0,
          mk("sins_enters", 4, 4'hF, 4'hF, 4'hF, 0, 0, 1, 0, 0));
    drive(0, 1, 4'h3, 4'h0, 4'hF, 64'h1, 0, 1, 0,
          mk("sins_stalled", 4, 4'hF, 4'hF, 4'hF, 0, 0, 1, 0, 0));
    drive(0, 1, 4'h3, 4'h0, 4'hF, 64'h1, 0, 0, 1,
          mk("sins_fault", 0, 1, 4'hF, 4'hF, 0, 0, 4, 1, 0));
    drive(1, 1, 4'h3, 4'h0, 4'hF, 64'h1, 0, 1, 1,
          mk("rst_mid_stall", 0, 1, 4'hF, 4'hF, 0, 0, 1, 0, 0));
    drive(0, 1, 4'h5, 4'hF, 4'h6, 0, 64'h33, 0, 0,
          mk("mrmovq", 1, 4'h5, 4'hF, 4'h6, 0, 64'h33, 1, 0, 0));
    drive(0, 1, 4'h1, 4'hF, 4'hF, 0, 0, 0, 0,
          mk("nop", 1, 4'h1, 4'hF, 4'hF, 0, 0, 1, 0, 1));

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
